dcache_write_buffer: RTL and testbench



---
 rtl/wb_types.sv | 26 ++
 rtl/wb_entry_array.sv | 95 +++++++++
 rtl/dcache_write_buffer.sv | 154 +++++++++++++++
 tb/tb_dcache_write_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_types.sv
// rtl/wb_types.sv - shared types and helpers for the D-cache write-back buffer
package wb_types;

    localparam int LINE_BITS = 256;

    typedef enum logic [1:0] {
        IDLE,
        RD_MEM,
        DRAIN,
        RESP
    } wb_state_t;

    // tag holds the full 32-bit line address with the byte-offset bits forced
    // to zero, so one struct serves any S_OFFSET and it can drive dn_addr as-is.
    typedef struct packed {
        logic                 valid;
        logic [31:0]          tag;
        logic [LINE_BITS-1:0] data;
    } wb_entry_t;

    function automatic logic [31:0] line_addr(input logic [31:0] addr,
                                              input int unsigned  s_offset);
        return addr & ~((32'h1 << s_offset) - 32'h1);
    endfunction

endpackage

// File: rtl/wb_entry_array.sv
// rtl/wb_entry_array.sv - circular line store with head/tail/count and tag CAM
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_*          append {tag,data} at tail (ignored when full)
//   pop_i           retire head entry (ignored when empty)
//   wr_en/idx/data  overwrite an entry's data in place (coalesce)
//   lookup_tag_i    line address compared against all valid entries
//   hit_o/idx/data  lookup result
//   head_o          entry at head, the next one to drain
//   full_o, empty_o occupancy flags; empty_o is registered
module wb_entry_array
    import wb_types::*;
#(
    parameter int DEPTH = 4,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [31:0]          push_tag_i,
    input  logic [LINE_BITS-1:0] push_data_i,
    input  logic                 pop_i,
    input  logic                 wr_en_i,
    input  logic [IDXW-1:0]      wr_idx_i,
    input  logic [LINE_BITS-1:0] wr_data_i,
    input  logic [31:0]          lookup_tag_i,
    output logic                 hit_o,
    output logic [IDXW-1:0]      hit_idx_o,
    output logic [LINE_BITS-1:0] hit_data_o,
    output wb_entry_t            head_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int CNTW = $clog2(DEPTH + 1);

    wb_entry_t       ent_q [DEPTH];
    logic [IDXW-1:0] head_q, tail_q;
    logic [CNTW-1:0] count_q, count_d;
    logic            empty_q;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CNTW'(DEPTH));
    assign empty_o = empty_q;
    assign head_o  = ent_q[head_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push_ok) count_d = count_d + CNTW'(1);
        if (pop_ok)  count_d = count_d - CNTW'(1);
    end

    // Coalescing on write keeps tags unique, so at most one entry can match.
    always_comb begin
        hit_o      = 1'b0;
        hit_idx_o  = '0;
        hit_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && ent_q[i].tag == lookup_tag_i) begin
                hit_o      = 1'b1;
                hit_idx_o  = IDXW'(i);
                hit_data_o = ent_q[i].data;
            end
        end
    end

    // Index widths equal log2(DEPTH), so head/tail wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            if (push_ok) begin
                ent_q[tail_q].valid <= 1'b1;
                ent_q[tail_q].tag   <= push_tag_i;
                ent_q[tail_q].data  <= push_data_i;
                tail_q              <= tail_q + IDXW'(1);
            end
            if (wr_en_i) ent_q[wr_idx_i].data <= wr_data_i;
            if (pop_ok) begin
                ent_q[head_q].valid <= 1'b0;
                head_q              <= head_q + IDXW'(1);
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// rtl/dcache_write_buffer.sv - write-back buffer between L2 D-cache and arbiter D-port
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   up_addr/wdata/read/write         cache-side request (held until up_resp)
//   up_rdata, up_resp                cache-side read line and one-cycle completion
//   dn_addr/wdata/read/write         arbiter-side request (held until dn_resp)
//   dn_rdata, dn_resp                arbiter-side read line and completion
//   buf_empty                        no buffered lines remain
module dcache_write_buffer
    import wb_types::*;
#(
    parameter int DEPTH    = 4,
    parameter int S_OFFSET = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          up_addr,
    input  logic [LINE_BITS-1:0] up_wdata,
    output logic [LINE_BITS-1:0] up_rdata,
    input  logic                 up_read,
    input  logic                 up_write,
    output logic                 up_resp,
    output logic [31:0]          dn_addr,
    output logic [LINE_BITS-1:0] dn_wdata,
    input  logic [LINE_BITS-1:0] dn_rdata,
    output logic                 dn_read,
    output logic                 dn_write,
    input  logic                 dn_resp,
    output logic                 buf_empty
);

    localparam int IDXW = $clog2(DEPTH);

    wb_state_t            state_q, state_d;
    logic [LINE_BITS-1:0] up_rdata_q, up_rdata_d;
    logic [LINE_BITS-1:0] dn_wdata_q, dn_wdata_d;
    logic [31:0]          dn_addr_q, dn_addr_d;
    logic                 dn_read_q, dn_read_d;
    logic                 dn_write_q, dn_write_d;

    logic [31:0]          req_tag;
    logic                 push, pop, wr_en;
    logic                 hit, full, empty;
    logic [IDXW-1:0]      hit_idx;
    logic [LINE_BITS-1:0] hit_data;
    wb_entry_t            head;

    assign req_tag = line_addr(up_addr, S_OFFSET);

    wb_entry_array #(.DEPTH(DEPTH)) u_array (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_tag_i   (req_tag),
        .push_data_i  (up_wdata),
        .pop_i        (pop),
        .wr_en_i      (wr_en),
        .wr_idx_i     (hit_idx),
        .wr_data_i    (up_wdata),
        .lookup_tag_i (req_tag),
        .hit_o        (hit),
        .hit_idx_o    (hit_idx),
        .hit_data_o   (hit_data),
        .head_o       (head),
        .full_o       (full),
        .empty_o      (empty)
    );

    assign up_rdata  = up_rdata_q;
    assign up_resp   = (state_q == RESP);
    assign dn_addr   = dn_addr_q;
    assign dn_wdata  = dn_wdata_q;
    assign dn_read   = dn_read_q;
    assign dn_write  = dn_write_q;
    assign buf_empty = empty;

    // dn_* are registered on entry to RD_MEM/DRAIN and held until dn_resp,
    // which keeps them stable and mutually exclusive by construction.
    always_comb begin
        state_d    = state_q;
        up_rdata_d = up_rdata_q;
        dn_addr_d  = dn_addr_q;
        dn_wdata_d = dn_wdata_q;
        dn_read_d  = dn_read_q;
        dn_write_d = dn_write_q;
        push       = 1'b0;
        pop        = 1'b0;
        wr_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Read wins over write if both are raised.
                if (up_read) begin
                    if (hit) begin
                        up_rdata_d = hit_data;
                        state_d    = RESP;
                    end else begin
                        dn_read_d = 1'b1;
                        dn_addr_d = req_tag;
                        state_d   = RD_MEM;
                    end
                end else if (up_write && hit) begin
                    wr_en   = 1'b1;
                    state_d = RESP;
                end else if (up_write && !full) begin
                    push    = 1'b1;
                    state_d = RESP;
                end else if (head.valid) begin
                    // Either idle with lines pending, or a write missed while
                    // full; in the latter case the write is retried on return.
                    dn_write_d = 1'b1;
                    dn_addr_d  = head.tag;
                    dn_wdata_d = head.data;
                    state_d    = DRAIN;
                end
            end
            RD_MEM: begin
                if (dn_resp) begin
                    up_rdata_d = dn_rdata;
                    dn_read_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            DRAIN: begin
                if (dn_resp) begin
                    pop        = 1'b1;
                    dn_write_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            up_rdata_q <= '0;
            dn_addr_q  <= '0;
            dn_wdata_q <= '0;
            dn_read_q  <= 1'b0;
            dn_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            up_rdata_q <= up_rdata_d;
            dn_addr_q  <= dn_addr_d;
            dn_wdata_q <= dn_wdata_d;
            dn_read_q  <= dn_read_d;
            dn_write_q <= dn_write_d;
        end
    end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb/tb_dcache_write_buffer.sv - directed self-checking bench for dcache_write_buffer
module tb_dcache_write_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  up_addr = '0;
    logic [255:0] up_wdata = '0;
    logic [255:0] up_rdata;
    logic         up_read = 1'b0;
    logic         up_write = 1'b0;
    logic         up_resp;
    logic [31:0]  dn_addr;
    logic [255:0] dn_wdata;
    logic [255:0] dn_rdata = '0;
    logic         dn_read;
    logic         dn_write;
    logic         dn_resp = 1'b0;
    logic         buf_empty;

    int tests = 0;
    int fails = 0;

    logic         auto_resp = 1'b1;
    logic [255:0] rd_val = '0;
    logic [31:0]  log_addr[$];
    logic         log_wr[$];
    logic [255:0] log_data[$];

    int           lat;
    logic [255:0] rdat;
    logic [255:0] da, db, dx, dy, d1, d2, d3, d4, d2n, d5, dp, dq, dz, dr;

    dcache_write_buffer #(.DEPTH(4), .S_OFFSET(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_addr   (up_addr),
        .up_wdata  (up_wdata),
        .up_rdata  (up_rdata),
        .up_read   (up_read),
        .up_write  (up_write),
        .up_resp   (up_resp),
        .dn_addr   (dn_addr),
        .dn_wdata  (dn_wdata),
        .dn_rdata  (dn_rdata),
        .dn_read   (dn_read),
        .dn_write  (dn_write),
        .dn_resp   (dn_resp),
        .buf_empty (buf_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and act as the arbiter: answer any
    // pending dn_read/dn_write immediately and log it.
    task automatic step();
        @(negedge clk);
        chk("dn_exclusive", {255'b0, dn_read & dn_write}, 256'd0);
        if (dn_resp) begin
            dn_resp = 1'b0;
        end else if (auto_resp && (dn_read || dn_write)) begin
            log_addr.push_back(dn_addr);
            log_wr.push_back(dn_write);
            log_data.push_back(dn_wdata);
            dn_rdata = rd_val;
            dn_resp  = 1'b1;
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_wr.delete();
        log_data.delete();
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [255:0] d, output int l, output logic [255:0] r);
        up_addr  = a;
        up_wdata = d;
        up_read  = rd;
        up_write = wr;
        l = 0;
        while (l < 40) begin
            step();
            l++;
            if (up_resp) break;
        end
        chk("up_resp_seen", {255'b0, up_resp}, 256'd1);
        r = up_rdata;
        up_read  = 1'b0;
        up_write = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60; i++) begin
            step();
            if (buf_empty && !dn_resp) break;
        end
        chk("drained_empty", {255'b0, buf_empty}, 256'd1);
    endtask

    initial begin
        da  = {8{32'hAAAA_0001}};
        db  = {8{32'hBBBB_0002}};
        dx  = {8{32'h1111_0003}};
        dy  = {8{32'h2222_0004}};
        d1  = {8{32'h0000_1001}};
        d2  = {8{32'h0000_2002}};
        d3  = {8{32'h0000_3003}};
        d4  = {8{32'h0000_4004}};
        d2n = {8{32'h0000_2EEE}};
        d5  = {8{32'h0000_5005}};
        dp  = {8{32'h6666_0006}};
        dq  = {8{32'h7777_0007}};
        dz  = {8{32'hDEAD_BEEF}};
        dr  = {8{32'h8888_0008}};

        // Reset state
        step();
        step();
        chk("rst_up_resp", {255'b0, up_resp}, 256'd0);
        chk("rst_up_rdata", up_rdata, 256'd0);
        chk("rst_dn_read", {255'b0, dn_read}, 256'd0);
        chk("rst_dn_write", {255'b0, dn_write}, 256'd0);
        chk("rst_dn_addr", {224'b0, dn_addr}, 256'd0);
        chk("rst_dn_wdata", dn_wdata, 256'd0);
        chk("rst_buf_empty", {255'b0, buf_empty}, 256'd1);
        rst = 1'b0;
        step();

        // 1: single write, then idle drain
        clear_log();
        req(1'b0, 1'b1, 32'h0000_0100, da, lat, rdat);
        chk("t1_lat", 256'(lat), 256'd1);
        chk("t1_no_dn", 256'(log_addr.size()), 256'd0);
        chk("t1_not_empty", {255'b0, buf_empty}, 256'd0);
        wait_empty();
        chk("t1_ndrain", 256'(log_addr.size()), 256'd1);
        chk("t1_addr", {224'b0, log_addr[0]}, 256'h100);
        chk("t1_wr", {255'b0, log_wr[0]}, 256'd1);
        chk("t1_data", log_data[0], da);

        // 2: read hit forwarded from buffer
        clear_log();
        req(1'b0, 1'b1, 32'h0000_0200, db, lat, rdat);
        step();
        req(1'b1, 1'b0, 32'h0000_0200, '0, lat, rdat);
        chk("t2_lat", 256'(lat), 256'd1);
        chk("t2_rdata", rdat, db);
        chk("t2_no_dn", 256'(log_addr.size()), 256'd0);
        wait_empty();
        chk("t2_ndrain", 256'(log_addr.size()), 256'd1);
        chk("t2_addr", {224'b0, log_addr[0]}, 256'h200);

        // 3: coalescing write
        clear_log();
        req(1'b0, 1'b1, 32'h0000_0300, dx, lat, rdat);
        step();
        req(1'b0, 1'b1, 32'h0000_0300, dy, lat, rdat);
        chk("t3_lat", 256'(lat), 256'd1);
        wait_empty();
        chk("t3_ndrain", 256'(log_addr.size()), 256'd1);
        chk("t3_data", log_data[0], dy);

        // 4: fill, coalesce while full, 5th write forces head drain
        clear_log();
        req(1'b0, 1'b1, 32'h0000_1000, d1, lat, rdat); step();
        req(1'b0, 1'b1, 32'h0000_2000, d2, lat, rdat); step();
        req(1'b0, 1'b1, 32'h0000_3000, d3, lat, rdat); step();
        req(1'b0, 1'b1, 32'h0000_4000, d4, lat, rdat); step();
        req(1'b0, 1'b1, 32'h0000_2010, d2n, lat, rdat);
        chk("t4_full_hit_lat", 256'(lat), 256'd1);
        chk("t4_full_hit_nodn", 256'(log_addr.size()), 256'd0);
        chk("t4_full_not_empty", {255'b0, buf_empty}, 256'd0);
        step();
        req(1'b0, 1'b1, 32'h0000_5000, d5, lat, rdat);
        chk("t4_lat5", 256'(lat), 256'd3);
        chk("t4_ndrain_at_resp", 256'(log_addr.size()), 256'd1);
        chk("t4_head_addr", {224'b0, log_addr[0]}, 256'h1000);
        wait_empty();
        chk("t4_ndrain", 256'(log_addr.size()), 256'd5);
        chk("t4_order1", {224'b0, log_addr[1]}, 256'h2000);
        chk("t4_coal_data", log_data[1], d2n);
        chk("t4_order2", {224'b0, log_addr[2]}, 256'h3000);
        chk("t4_order3", {224'b0, log_addr[3]}, 256'h4000);
        chk("t4_order4", {224'b0, log_addr[4]}, 256'h5000);
        chk("t4_data4", log_data[4], d5);

        // 5: read miss bypasses pending writes
        clear_log();
        req(1'b0, 1'b1, 32'h0000_0600, dp, lat, rdat); step();
        req(1'b0, 1'b1, 32'h0000_0700, dq, lat, rdat); step();
        rd_val = dz;
        req(1'b1, 1'b0, 32'h0000_041F, '0, lat, rdat);
        chk("t5_lat", 256'(lat), 256'd2);
        chk("t5_rdata", rdat, dz);
        chk("t5_first_is_read", {255'b0, log_wr[0]}, 256'd0);
        chk("t5_rd_addr", {224'b0, log_addr[0]}, 256'h400);
        wait_empty();
        chk("t5_ntxn", 256'(log_addr.size()), 256'd3);
        chk("t5_drain0", {224'b0, log_addr[1]}, 256'h600);
        chk("t5_drain1", {224'b0, log_addr[2]}, 256'h700);
        chk("t5_drain1_data", log_data[2], dq);

        // 6: reset while draining
        clear_log();
        req(1'b0, 1'b1, 32'h0000_0800, dr, lat, rdat);
        auto_resp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dn_write) break;
        end
        chk("t6_dn_write_up", {255'b0, dn_write}, 256'd1);
        chk("t6_dn_addr", {224'b0, dn_addr}, 256'h800);
        rst = 1'b1;
        step();
        chk("t6_dn_write_drop", {255'b0, dn_write}, 256'd0);
        chk("t6_empty", {255'b0, buf_empty}, 256'd1);
        rst = 1'b0;
        auto_resp = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("t6_no_resume", 256'(log_addr.size()), 256'd0);
        chk("t6_still_empty", {255'b0, buf_empty}, 256'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
